// File: rtl/neuron_pkg.sv
// Shared types and Q8.8 helpers for the neuron datapath.
// The saturating helper works on a sign-extended 64-bit accumulator view.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int FRAC_BITS = 8;
  localparam int SAT_W     = 64;

  // Floor-shift by the fractional bits, then clamp into signed Q8.8.
  function automatic logic [15:0] sat_q88(input logic signed [SAT_W-1:0] acc);
    logic signed [SAT_W-1:0] shifted;
    shifted = acc >>> FRAC_BITS;
    if (shifted > 64'sd32767) begin
      return 16'h7FFF;
    end else if (shifted < -64'sd32768) begin
      return 16'h8000;
    end else begin
      return shifted[15:0];
    end
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Registered signed multiply-accumulate with clear/enable and a saturated Q8.8 result register.
// clr_i wins over en_i; load_i captures sat(acc) into sum_o on the next edge.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]          sum_q, sum_d;

  assign prod = $signed(a_i) * $signed(b_i);

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
    if (load_i) begin
      sum_d = sat_q88(SAT_W'(acc_q));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/neuron_weight_reader.sv
// Walks weight ROM addresses in lockstep with accepted activations and MACs them.
// Emits one saturated Q8.8 sum per start; the result is held until sum_ready.
module neuron_weight_reader
  import neuron_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int N_INPUTS  = 10,
  parameter int BASE_ADDR = 1,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [DATA_W-1:0] sum_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              mac_v_q, mac_v_d;
  logic              sum_valid_q, sum_valid_d;
  logic              acc_clr, sum_load;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    mac_v_d     = 1'b0;
    sum_valid_d = sum_valid_q;
    acc_clr     = 1'b0;
    sum_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_clr = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The ROM samples rom_addr on this same edge, so rom_dout pairs with x_q next cycle.
        if (x_valid) begin
          x_d     = x_data;
          mac_v_d = 1'b1;
          if (idx_q == ADDR_W'(N_INPUTS - 1)) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        // First OUT cycle lets the final MAC land before the result is captured.
        if (!sum_valid_q) begin
          sum_load    = 1'b1;
          sum_valid_d = 1'b1;
        end else if (sum_ready) begin
          sum_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      mac_v_q     <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      mac_v_q     <= mac_v_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  neuron_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (acc_clr),
    .en_i  (mac_v_q),
    .load_i(sum_load),
    .a_i   (rom_dout),
    .b_i   (x_q),
    .sum_o (sum_data)
  );

  assign rom_addr  = ADDR_W'(BASE_ADDR) + idx_q;
  assign x_ready   = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_neuron_weight_reader.sv
// Bench for neuron_weight_reader: ROM model plus a plain-arithmetic dot-product reference.
module tb_neuron_weight_reader;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [15:0] x_data = '0;
  logic [15:0] rom_addr;
  logic [15:0] rom_dout = '0;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [15:0] sum_data;

  logic [15:0] rom [0:15];
  logic [15:0] xs  [0:N-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= rom[rom_addr[3:0]];

  neuron_weight_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_data   (x_data),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .sum_data (sum_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_sum();
    longint s;
    s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(rom[i+1])) * longint'($signed(xs[i]));
    s = s >>> 8;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic set_ramp_weights();
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 1; i <= 6; i++) rom[i] = 16'(i * 256);
  endtask

  task automatic set_xs(input logic [15:0] v);
    for (int i = 0; i < N; i++) xs[i] = v;
  endtask

  // mode 0: gap-free, 1: valid every other cycle, 2: random gaps
  task automatic drive_run(input int mode, input bit start_mid,
                           output int lat, output int addr_err, output int busy_err);
    int  k;
    int  cyc;
    bit  v;
    k = 0; cyc = 0; addr_err = 0; busy_err = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (k < N && cyc < 200) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      start   = start_mid && (k == 3);
      x_valid = v;
      x_data  = xs[k];
      if (!busy) busy_err++;
      if (rom_addr !== 16'(1 + k)) addr_err++;
      if (v && x_ready) k++;
      tick();
      cyc++;
    end
    start = 1'b0;
    x_valid = 1'b0;
    while (!sum_valid && cyc < 200) begin
      if (!busy) busy_err++;
      tick();
      cyc++;
    end
    lat = cyc;
  endtask

  task automatic accept_sum();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL reset_x_ready got=%b exp=0", x_ready); end
    n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid got=%b exp=0", sum_valid); end
    n_tests++; if (sum_data !== 16'h0000) begin n_fail++; $display("FAIL reset_sum_data got=%h exp=0000", sum_data); end
    n_tests++; if (rom_addr !== 16'h0001) begin n_fail++; $display("FAIL reset_rom_addr got=%h exp=0001", rom_addr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, ae, be;
    set_ramp_weights();
    set_xs(16'h0100);
    drive_run(0, 1'b0, lat, ae, be);
    n_tests++; if (lat != N + 2) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, N + 2); end
    n_tests++; if (sum_data !== 16'h1500) begin n_fail++; $display("FAIL basic_sum got=%h exp=1500", sum_data); end
    n_tests++; if (ae != 0) begin n_fail++; $display("FAIL basic_addr_seq bad_cycles=%0d exp=0", ae); end
    n_tests++; if (be != 0) begin n_fail++; $display("FAIL basic_busy low_cycles=%0d exp=0", be); end
    accept_sum();
    n_tests++; if (busy !== 1'b0 || sum_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_after busy=%b sum_valid=%b exp=0/0", busy, sum_valid);
    end
  endtask

  task automatic test_gaps();
    int lat, ae, be;
    set_ramp_weights();
    set_xs(16'h0080);
    drive_run(1, 1'b0, lat, ae, be);
    n_tests++; if (sum_data !== 16'h0A80 || sum_valid !== 1'b1) begin
      n_fail++; $display("FAIL gaps_sum got=%h valid=%b exp=0a80", sum_data, sum_valid);
    end
    n_tests++; if (ae != 0) begin n_fail++; $display("FAIL gaps_addr_hold bad_cycles=%0d exp=0", ae); end
    accept_sum();
  endtask

  task automatic test_saturation();
    int lat, ae, be;
    set_ramp_weights();
    set_xs(16'h7FFF);
    drive_run(0, 1'b0, lat, ae, be);
    n_tests++; if (sum_data !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos got=%h exp=7fff", sum_data); end
    accept_sum();
    tick();
    set_xs(16'h8000);
    drive_run(0, 1'b0, lat, ae, be);
    n_tests++; if (sum_data !== 16'h8000) begin n_fail++; $display("FAIL sat_neg got=%h exp=8000", sum_data); end
    accept_sum();
  endtask

  task automatic test_out_hold();
    int lat, ae, be, bad;
    set_ramp_weights();
    set_xs(16'h0100);
    drive_run(0, 1'b0, lat, ae, be);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      if (sum_valid !== 1'b1 || sum_data !== 16'h1500 || busy !== 1'b1) bad++;
      tick();
    end
    start = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
    n_tests++; if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_before_ack got=%b exp=1", sum_valid); end
    start = 1'b1;
    accept_sum();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || sum_valid !== 1'b0) bad++;
      tick();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_start_ignored bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_abort();
    int lat, ae, be, bad;
    set_ramp_weights();
    set_xs(16'h0100);
    start = 1'b1;
    tick();
    start = 1'b0;
    x_valid = 1'b1;
    x_data = 16'h0100;
    repeat (4) tick();
    x_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sum_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL abort_no_output bad_cycles=%0d exp=0", bad); end
    drive_run(0, 1'b0, lat, ae, be);
    n_tests++; if (sum_data !== 16'h1500 || lat != N + 2) begin
      n_fail++; $display("FAIL abort_fresh_sum got=%h lat=%0d exp=1500 lat=%0d", sum_data, lat, N + 2);
    end
    accept_sum();
  endtask

  task automatic test_start_in_run();
    int lat, ae, be;
    set_ramp_weights();
    set_xs(16'h0100);
    drive_run(0, 1'b1, lat, ae, be);
    n_tests++; if (sum_data !== 16'h1500 || lat != N + 2) begin
      n_fail++; $display("FAIL run_start_sum got=%h lat=%0d exp=1500 lat=%0d", sum_data, lat, N + 2);
    end
    n_tests++; if (ae != 0) begin n_fail++; $display("FAIL run_start_addr bad_cycles=%0d exp=0", ae); end
    accept_sum();
  endtask

  task automatic test_random();
    int lat, ae, be, hold;
    logic [15:0] exp_sum;
    for (int it = 0; it < 10; it++) begin
      rom[0] = '0;
      for (int i = 1; i < 16; i++) begin
        rom[i] = 16'($urandom);
        if (it % 2 == 0) rom[i] = 16'($signed(rom[i]) >>> 5);
      end
      for (int i = 0; i < N; i++) begin
        xs[i] = 16'($urandom);
        if (it % 2 == 0) xs[i] = 16'($signed(xs[i]) >>> 4);
      end
      exp_sum = model_sum();
      drive_run(2, it[0], lat, ae, be);
      hold = $urandom_range(0, 3);
      repeat (hold) tick();
      n_tests++; if (sum_valid !== 1'b1 || sum_data !== exp_sum) begin
        n_fail++; $display("FAIL random_%0d got=%h valid=%b exp=%h", it, sum_data, sum_valid, exp_sum);
      end
      n_tests++; if (ae != 0 || be != 0) begin
        n_fail++; $display("FAIL random_ctrl_%0d addr_bad=%0d busy_bad=%0d exp=0/0", it, ae, be);
      end
      accept_sum();
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < N; i++) xs[i] = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_out_hold();
    test_reset_abort();
    test_start_in_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
